// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and datapath widths.
package alu_pkg;
  localparam int ALU_OP_W = 5;
  localparam int XLEN     = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD  = 5'd0,
    SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
    IMM  = 5'd17
  } alu_op_e;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two request ports, the ALU drive/return and the response slot.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(parameter int TAG_W = 4);
  // valid/ready: a transfer happens on a rising edge where both are high; the
  // source holds valid and payload stable until then, and ready may depend on valid.
  logic             req0_valid, req0_ready;
  alu_op_e          req0_op;
  logic [XLEN-1:0]  req0_a, req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid, req1_ready;
  alu_op_e          req1_op;
  logic [XLEN-1:0]  req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;

  alu_op_e          alu_op;
  logic [XLEN-1:0]  alu_a, alu_b, alu_result;
  logic             alu_flag;

  logic             rsp_valid, rsp_ready, rsp_src, rsp_flag;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0]  rsp_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result, alu_flag,
    output rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_flag,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result, alu_flag,
    input  rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_flag,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way grant logic with a round-robin pointer; ARB_MODE=1 makes port 0 always win.
module rr_arb2 #(
  parameter int ARB_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic rr_ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ARB_MODE == 1 || !rr_ptr) ? 2'b01 : 2'b10;
    end
  end

  // Pointer moves to the loser only when both ports competed for the accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (advance && req == 2'b11) begin
      rr_ptr <= gnt[0];
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters and registers
// the result into a single-entry response slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);
  logic             slot_free, accept;
  logic [1:0]       req, gnt;
  alu_op_e          sel_op;
  logic [XLEN-1:0]  sel_a, sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_src;

  // A full slot can be refilled on the same edge it drains.
  assign slot_free = !bus.rsp_valid || bus.rsp_ready;
  assign req       = {bus.req1_valid, bus.req0_valid} & {2{slot_free && !rst}};
  assign accept    = |gnt;

  rr_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    sel_op  = ADD;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    sel_src = 1'b0;
    if (gnt[0]) begin
      sel_op  = bus.req0_op;
      sel_a   = bus.req0_a;
      sel_b   = bus.req0_b;
      sel_tag = bus.req0_tag;
    end else if (gnt[1]) begin
      sel_op  = bus.req1_op;
      sel_a   = bus.req1_a;
      sel_b   = bus.req1_b;
      sel_tag = bus.req1_tag;
      sel_src = 1'b1;
    end
  end

  assign bus.alu_op = sel_op;
  assign bus.alu_a  = sel_a;
  assign bus.alu_b  = sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_src    <= 1'b0;
      bus.rsp_tag    <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flag   <= 1'b0;
    end else if (accept) begin
      bus.rsp_valid  <= 1'b1;
      bus.rsp_src    <= sel_src;
      bus.rsp_tag    <= sel_tag;
      bus.rsp_result <= bus.alu_result;
      bus.rsp_flag   <= bus.alu_flag;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter: round-robin and fixed-priority instances.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  vec_t        vec0_q[$];
  vec_t        vec1_q[$];
  logic [37:0] exp_q[$];
  logic [37:0] exp2_q[$];

  alu_share_arbiter_if #(.TAG_W(4)) bus_rr ();
  alu_share_arbiter_if #(.TAG_W(4)) bus_fp ();

  alu_share_arbiter #(.TAG_W(4), .ARB_MODE(0)) u_dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  alu_share_arbiter #(.TAG_W(4), .ARB_MODE(1)) u_dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model (external to the DUT) ----------------
  function automatic logic [32:0] alu_model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    r = '0;
    f = 1'b0;
    case (op)
      ADD: r = a + b;
      SUB: r = a - b;
      BLT: f = ($signed(a) < $signed(b));
      default: ;
    endcase
    return {r, f};
  endfunction

  always_comb begin
    {bus_rr.alu_result, bus_rr.alu_flag} = alu_model(bus_rr.alu_op, bus_rr.alu_a, bus_rr.alu_b);
    {bus_fp.alu_result, bus_fp.alu_flag} = alu_model(bus_fp.alu_op, bus_fp.alu_a, bus_fp.alu_b);
  end

  // ---------------- helpers ----------------
  function automatic logic [37:0] ex(input logic src, input logic [3:0] tag,
                                     input logic [31:0] r, input logic f);
    return {src, tag, r, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0();
    if (vec0_q.size() > 0) begin
      bus_rr.req0_valid = 1'b1;
      bus_rr.req0_op    = vec0_q[0].op;
      bus_rr.req0_a     = vec0_q[0].a;
      bus_rr.req0_b     = vec0_q[0].b;
      bus_rr.req0_tag   = vec0_q[0].tag;
    end else begin
      bus_rr.req0_valid = 1'b0;
      bus_rr.req0_op    = ADD;
      bus_rr.req0_a     = '0;
      bus_rr.req0_b     = '0;
      bus_rr.req0_tag   = '0;
    end
  endtask

  task automatic drive1();
    if (vec1_q.size() > 0) begin
      bus_rr.req1_valid = 1'b1;
      bus_rr.req1_op    = vec1_q[0].op;
      bus_rr.req1_a     = vec1_q[0].a;
      bus_rr.req1_b     = vec1_q[0].b;
      bus_rr.req1_tag   = vec1_q[0].tag;
    end else begin
      bus_rr.req1_valid = 1'b0;
      bus_rr.req1_op    = ADD;
      bus_rr.req1_a     = '0;
      bus_rr.req1_b     = '0;
      bus_rr.req1_tag   = '0;
    end
  endtask

  task automatic push0(input vec_t v);
    vec0_q.push_back(v);
    drive0();
  endtask

  task automatic push1(input vec_t v);
    vec1_q.push_back(v);
    drive1();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((vec0_q.size() + vec1_q.size() + exp_q.size() + exp2_q.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 64'(n < 50), 64'd1);
    tick();
  endtask

  // Feeders retire the head vector of each port after its handshake edge.
  initial begin
    logic acc0;
    forever begin
      @(negedge clk);
      acc0 = bus_rr.req0_valid && bus_rr.req0_ready;
      @(posedge clk);
      #1;
      if (acc0 && vec0_q.size() > 0) void'(vec0_q.pop_front());
      drive0();
    end
  end

  initial begin
    logic acc1;
    forever begin
      @(negedge clk);
      acc1 = bus_rr.req1_valid && bus_rr.req1_ready;
      @(posedge clk);
      #1;
      if (acc1 && vec1_q.size() > 0) void'(vec1_q.pop_front());
      drive1();
    end
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst && bus_rr.rsp_valid && bus_rr.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rr_rsp: unexpected response src=%0d tag=%0d, required none",
                 bus_rr.rsp_src, bus_rr.rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check("rr_rsp", {bus_rr.rsp_src, bus_rr.rsp_tag, bus_rr.rsp_result, bus_rr.rsp_flag}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst && bus_fp.rsp_valid && bus_fp.rsp_ready) begin
      if (exp2_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL fp_rsp: unexpected response src=%0d tag=%0d, required none",
                 bus_fp.rsp_src, bus_fp.rsp_tag);
      end else begin
        e = exp2_q.pop_front();
        check("fp_rsp", {bus_fp.rsp_src, bus_fp.rsp_tag, bus_fp.rsp_result, bus_fp.rsp_flag}, e);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    drive0();
    drive1();
    bus_rr.rsp_ready  = 1'b1;
    bus_fp.req0_valid = 1'b0; bus_fp.req0_op = ADD; bus_fp.req0_a = '0; bus_fp.req0_b = '0; bus_fp.req0_tag = '0;
    bus_fp.req1_valid = 1'b0; bus_fp.req1_op = ADD; bus_fp.req1_a = '0; bus_fp.req1_b = '0; bus_fp.req1_tag = '0;
    bus_fp.rsp_ready  = 1'b1;

    // Reset with both ports valid; first contention after reset goes to port 0.
    tick();
    push0('{ADD, 32'd1, 32'd1, 4'd1});
    push1('{ADD, 32'd2, 32'd2, 4'd2});
    exp_q.push_back(ex(1'b0, 4'd1, 32'd2, 1'b0));
    exp_q.push_back(ex(1'b1, 4'd2, 32'd4, 1'b0));
    repeat (3) begin
      @(negedge clk);
      check("reset_req0_ready", bus_rr.req0_ready, 0);
      check("reset_req1_ready", bus_rr.req1_ready, 0);
      check("reset_rsp_valid",  bus_rr.rsp_valid,  0);
    end
    tick();
    rst = 1'b0;
    wait_idle("reset_contention");

    // Single op: ADD 5+7 tag 3.
    push0('{ADD, 32'd5, 32'd7, 4'd3});
    exp_q.push_back(ex(1'b0, 4'd3, 32'd12, 1'b0));
    @(negedge clk);
    check("single_req0_ready", bus_rr.req0_ready, 1);
    wait_idle("single");

    // Backpressure: BLT -1 < 2 held in the slot while SUB waits.
    bus_rr.rsp_ready = 1'b0;
    push1('{BLT, 32'hFFFF_FFFF, 32'd2, 4'd8});
    exp_q.push_back(ex(1'b1, 4'd8, 32'd0, 1'b1));
    @(negedge clk);
    check("bp_req1_ready", bus_rr.req1_ready, 1);
    tick();
    push0('{SUB, 32'd10, 32'd3, 4'd9});
    exp_q.push_back(ex(1'b0, 4'd9, 32'd7, 1'b0));
    repeat (5) begin
      @(negedge clk);
      check("bp_req0_ready", bus_rr.req0_ready, 0);
      check("bp_req1_ready", bus_rr.req1_ready, 0);
      check("bp_rsp_valid",  bus_rr.rsp_valid,  1);
      check("bp_rsp_flag",   bus_rr.rsp_flag,   1);
      check("bp_alu_op",     bus_rr.alu_op,     ADD);
      check("bp_alu_a",      bus_rr.alu_a,      0);
      check("bp_alu_b",      bus_rr.alu_b,      0);
    end
    tick();
    bus_rr.rsp_ready = 1'b1;
    @(negedge clk);
    check("release_refill_req0_ready", bus_rr.req0_ready, 1);
    wait_idle("backpressure");

    // Reset while a response (tag 10) sits unconsumed: it must vanish.
    bus_rr.rsp_ready = 1'b0;
    push0('{ADD, 32'd1, 32'd2, 4'd10});
    tick();
    @(negedge clk);
    check("midrst_pre_valid", bus_rr.rsp_valid, 1);
    check("midrst_pre_tag",   bus_rr.rsp_tag,   10);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_valid",      bus_rr.rsp_valid,  0);
    check("midrst_req0_ready", bus_rr.req0_ready, 0);
    rst = 1'b0;
    bus_rr.rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("postrst_valid", bus_rr.rsp_valid, 0);
      check("postrst_tag",   bus_rr.rsp_tag,   0);
    end
    tick();

    // Round-robin contention: order 0,1,0,1 with one accept per cycle.
    push0('{ADD, 32'd10,  32'd20, 4'd4});
    push0('{SUB, 32'd100, 32'd1,  4'd5});
    push1('{ADD, 32'd3,   32'd4,  4'd6});
    push1('{SUB, 32'd0,   32'd1,  4'd7});
    exp_q.push_back(ex(1'b0, 4'd4, 32'd30, 1'b0));
    exp_q.push_back(ex(1'b1, 4'd6, 32'd7, 1'b0));
    exp_q.push_back(ex(1'b0, 4'd5, 32'd99, 1'b0));
    exp_q.push_back(ex(1'b1, 4'd7, 32'hFFFF_FFFF, 1'b0));
    repeat (4) begin
      @(negedge clk);
      check("rr_one_accept_per_cycle", 64'(bus_rr.req0_ready) + 64'(bus_rr.req1_ready), 1);
    end
    wait_idle("rr_contention");

    // Fixed priority instance: port 0 wins every contended cycle.
    for (int k = 0; k < 3; k++) begin
      bus_fp.req0_valid = 1'b1;
      bus_fp.req0_op    = ADD;
      bus_fp.req0_a     = 32'(k + 1);
      bus_fp.req0_b     = 32'd0;
      bus_fp.req0_tag   = 4'(k);
      bus_fp.req1_valid = 1'b1;
      bus_fp.req1_op    = ADD;
      bus_fp.req1_a     = 32'd9;
      bus_fp.req1_b     = 32'd9;
      bus_fp.req1_tag   = 4'd15;
      exp2_q.push_back(ex(1'b0, 4'(k), 32'(k + 1), 1'b0));
      @(negedge clk);
      check("fp_req0_ready", bus_fp.req0_ready, 1);
      check("fp_req1_ready", bus_fp.req1_ready, 0);
      tick();
    end
    bus_fp.req0_valid = 1'b0;
    bus_fp.req1_valid = 1'b0;
    wait_idle("fixed_priority");

    check("rr_leftover_expected", 64'(exp_q.size()),  0);
    check("fp_leftover_expected", 64'(exp2_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end
endmodule
